config_stream_tx: RTL

Transmit side of the fabric configuration word protocol. It takes whole frames (an address plus NumberOfRows row words read from a frame buffer) and emits the 32-bit word stream the configuration FSM consumes: sync word, then per frame a header and its row words, then a desync word. Sits between the bitstream source (SPI/DMA frame buffer) and the fabric config port, or a UART/parallel serializer.

---
 rtl/config_pkg.sv | 27 ++
 rtl/config_stream_tx_if.sv | 34 +++
 rtl/config_tx_outreg.sv | 42 ++++
 rtl/config_stream_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared constants and tx state encoding for the config word protocol
//
// Purpose: protocol words, desync flag position and transmitter state
//          encoding, shared by the transmitter and the receiver FSM.
// Ports:   none (package).
package config_pkg;

  localparam logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1;
  localparam logic [31:0] PREAMBLE_WORD = 32'hFFFF_FFFF;
  localparam int          DESYNC_FLAG   = 20;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PRE,
    TX_SYNC,
    TX_HDR,
    TX_RD,
    TX_LD,
    TX_DESYNC
  } tx_state_t;

  // Desync word: a header-shaped word with only the desync flag set.
  function automatic logic [31:0] desync_word(input int flag);
    return 32'h1 << flag;
  endfunction

endpackage

// File: rtl/config_stream_tx_if.sv
// rtl/config_stream_tx_if.sv - frame request, row read and word stream bundle
//
// Purpose: groups the handshake/bus signals of config_stream_tx.
// Signals: FrameValid/FrameReady/FrameAddress/FrameLast  frame request
//          RowRdEn/RowAddr/RowRdData                      frame buffer read
//          WriteData/WriteStrobe/WriteReady               protocol word stream
// Modports: slave = transmitter view, master = source/sink view.
interface config_stream_tx_if #(
  parameter int FrameBitsPerRow = 32,
  parameter int RowSelectWidth  = 5
);

  logic                       FrameValid;
  logic                       FrameReady;
  logic [FrameBitsPerRow-1:0] FrameAddress;
  logic                       FrameLast;
  logic                       RowRdEn;
  logic [RowSelectWidth-1:0]  RowAddr;
  logic [31:0]                RowRdData;
  logic [31:0]                WriteData;
  logic                       WriteStrobe;
  logic                       WriteReady;

  modport slave (
    input  FrameValid, FrameAddress, FrameLast, RowRdData, WriteReady,
    output FrameReady, RowRdEn, RowAddr, WriteData, WriteStrobe
  );

  modport master (
    output FrameValid, FrameAddress, FrameLast, RowRdData, WriteReady,
    input  FrameReady, RowRdEn, RowAddr, WriteData, WriteStrobe
  );

endinterface

// File: rtl/config_tx_outreg.sv
// rtl/config_tx_outreg.sv - single-entry valid/ready output word register
//
// Purpose: holds WriteData/WriteStrobe stable until the sink accepts.
// Ports:   i_clk, i_reset (sync, active-high)
//          i_load/i_data   load a new word (only when o_can_load)
//          i_ready         sink accepts
//          o_data/o_valid  registered word and strobe
//          o_can_load      empty, or emptying this cycle
//          o_xfer          word transferred this cycle
module config_tx_outreg (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_can_load,
  output logic        o_xfer
);

  logic        r_valid;
  logic [31:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_can_load = !r_valid || i_ready;
  assign o_xfer     = r_valid && i_ready;

endmodule

// File: rtl/config_stream_tx.sv
// rtl/config_stream_tx.sv - frame-to-config-word stream transmitter
//
// Purpose: emits sync, per frame a header plus NumberOfRows row words
//          (row NumberOfRows down to 1), then desync.
// Ports:   CLK, Reset (sync, active-high)
//          bus          config_stream_tx_if.slave (frame request, row read, word stream)
//          Busy         state is not IDLE
//          ErrorStrobe  pulse when a frame with the desync flag is rejected
// Option:  CONFIG_TX_PREAMBLE_EN adds PreambleWords all-ones words before sync.
module config_stream_tx
  import config_pkg::*;
#(
  parameter int NumberOfRows    = 12,
  parameter int RowSelectWidth  = 5,
  parameter int FrameBitsPerRow = 32,
  parameter int desync_flag     = DESYNC_FLAG
`ifdef CONFIG_TX_PREAMBLE_EN
  , parameter int PreambleWords = 4
`endif
) (
  input  logic              CLK,
  input  logic              Reset,
  config_stream_tx_if.slave bus,
  output logic              Busy,
  output logic              ErrorStrobe
);

  localparam logic [31:0]               DesyncWord = desync_word(desync_flag);
  localparam logic [RowSelectWidth-1:0] RowsInit   = RowSelectWidth'(NumberOfRows);
  localparam logic [RowSelectWidth-1:0] RowOne     = RowSelectWidth'(1);

  tx_state_t                 r_state;
  tx_state_t                 w_next_state;
  logic [RowSelectWidth-1:0] r_cnt;
  logic [RowSelectWidth-1:0] w_cnt_next;
  logic                      r_last;
  logic                      w_last_next;
  logic                      r_desync_loaded;
  logic                      w_desync_loaded_next;
  logic                      w_load;
  logic [31:0]               w_load_data;
  logic                      w_frame_ready;
  logic                      w_error;
  logic                      w_row_rd_en;
  logic [31:0]               w_hdr;
  logic [31:0]               w_wdata;
  logic                      w_wvalid;
  logic                      w_can_load;
  logic                      w_xfer;
`ifdef CONFIG_TX_PREAMBLE_EN
  localparam logic [7:0]     PreLast = 8'(PreambleWords - 1);
  logic [7:0]                r_pre_cnt;
  logic [7:0]                w_pre_cnt_next;
`endif

  config_tx_outreg u_outreg (
    .i_clk      (CLK),
    .i_reset    (Reset),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_ready    (bus.WriteReady),
    .o_data     (w_wdata),
    .o_valid    (w_wvalid),
    .o_can_load (w_can_load),
    .o_xfer     (w_xfer)
  );

  // Zero-extended header; the flag test uses the extended word so it is
  // simply 0 when the address is narrower than the flag position.
  always_comb begin
    w_hdr = '0;
    w_hdr[FrameBitsPerRow-1:0] = bus.FrameAddress;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state         <= TX_IDLE;
      r_cnt           <= '0;
      r_last          <= 1'b0;
      r_desync_loaded <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_cnt           <= w_cnt_next;
      r_last          <= w_last_next;
      r_desync_loaded <= w_desync_loaded_next;
    end
  end

`ifdef CONFIG_TX_PREAMBLE_EN
  always_ff @(posedge CLK) begin
    if (Reset) r_pre_cnt <= '0;
    else       r_pre_cnt <= w_pre_cnt_next;
  end
`endif

  // Words are loaded on the transition into the state that owns them, so
  // the first word leaves one cycle after FrameValid and each state only
  // waits for its own transfer.
  always_comb begin
    w_next_state         = r_state;
    w_cnt_next           = r_cnt;
    w_last_next          = r_last;
    w_desync_loaded_next = r_desync_loaded;
    w_load               = 1'b0;
    w_load_data          = '0;
    w_frame_ready        = 1'b0;
    w_error              = 1'b0;
    w_row_rd_en          = 1'b0;
`ifdef CONFIG_TX_PREAMBLE_EN
    w_pre_cnt_next       = r_pre_cnt;
`endif
    case (r_state)
      TX_IDLE: begin
        if (bus.FrameValid) begin
          w_load = 1'b1;
`ifdef CONFIG_TX_PREAMBLE_EN
          w_load_data    = PREAMBLE_WORD;
          w_pre_cnt_next = PreLast;
          w_next_state   = TX_PRE;
`else
          w_load_data  = SYNC_WORD;
          w_next_state = TX_SYNC;
`endif
        end
      end
`ifdef CONFIG_TX_PREAMBLE_EN
      TX_PRE: begin
        if (w_xfer) begin
          w_load = 1'b1;
          if (r_pre_cnt == 8'd0) begin
            w_load_data  = SYNC_WORD;
            w_next_state = TX_SYNC;
          end else begin
            w_load_data    = PREAMBLE_WORD;
            w_pre_cnt_next = r_pre_cnt - 8'd1;
          end
        end
      end
`endif
      TX_SYNC: begin
        if (w_xfer) w_next_state = TX_HDR;
      end
      TX_HDR: begin
        // The previous frame's last row may still be draining here.
        if (bus.FrameValid && w_can_load) begin
          w_frame_ready = 1'b1;
          if (w_hdr[desync_flag]) begin
            w_error = 1'b1;
            if (bus.FrameLast) w_next_state = TX_DESYNC;
          end else begin
            w_load       = 1'b1;
            w_load_data  = w_hdr;
            w_last_next  = bus.FrameLast;
            w_cnt_next   = RowsInit;
            w_next_state = TX_RD;
          end
        end
      end
      TX_RD: begin
        // Reading while the previous word transfers guarantees LD finds the
        // register free when the read data arrives.
        if (w_can_load) begin
          w_row_rd_en  = 1'b1;
          w_next_state = TX_LD;
        end
      end
      TX_LD: begin
        w_load      = 1'b1;
        w_load_data = bus.RowRdData;
        w_cnt_next  = r_cnt - RowOne;
        if (r_cnt == RowOne) w_next_state = r_last ? TX_DESYNC : TX_HDR;
        else                 w_next_state = TX_RD;
      end
      TX_DESYNC: begin
        if (!r_desync_loaded) begin
          if (w_can_load) begin
            w_load               = 1'b1;
            w_load_data          = DesyncWord;
            w_desync_loaded_next = 1'b1;
          end
        end else if (w_xfer) begin
          w_desync_loaded_next = 1'b0;
          w_next_state         = TX_IDLE;
        end
      end
      default: w_next_state = TX_IDLE;
    endcase
  end

  assign bus.FrameReady  = w_frame_ready;
  assign bus.RowRdEn     = w_row_rd_en;
  assign bus.RowAddr     = r_cnt;
  assign bus.WriteData   = w_wdata;
  assign bus.WriteStrobe = w_wvalid;
  assign Busy            = (r_state != TX_IDLE);
  assign ErrorStrobe     = w_error;

endmodule
